// File: rtl/instruction_fetch_pkg.sv
// Shared types for the fetch stage: FSM state encoding and the bubble instruction.
package fetch_pkg;
    typedef enum logic [1:0] {FILL, RUN, HALTED} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch <-> datapath/ROM bundle; master is the fetch stage, slave is the datapath and ROM side.
interface instruction_fetch_if #(parameter int AW = 6);
    logic [31:0]   npc_in;
    logic          halt_in;
    logic          stall_in;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_q;
    logic [31:0]   instr_out;
    logic [31:0]   pc_out;
    logic          instr_valid;
    logic          halted;
    logic          fault;
    logic [31:0]   fault_addr;
    logic [31:0]   retired;

    modport master (
        input  npc_in, halt_in, stall_in, rom_q,
        output rom_addr, instr_out, pc_out, instr_valid, halted, fault, fault_addr, retired
    );

    modport slave (
        output npc_in, halt_in, stall_in, rom_q,
        input  rom_addr, instr_out, pc_out, instr_valid, halted, fault, fault_addr, retired
    );
endinterface

// File: rtl/instruction_fetch_sat_counter.sv
// 32-bit saturating event counter; one-cycle update latency, sticks at all-ones, no backpressure.
module sat_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    output logic [31:0] count
);
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/instruction_fetch.sv
// Registered PC / ROM fetch stage: one-cycle fetch latency, one FILL bubble after reset.
// Stall holds the current instruction and PC; halt or a bad next-PC stops fetch until reset.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          AW       = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic                clk,
    input  logic                reset_n,
    instruction_fetch_if.master bus
);
    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  fault_addr_q;
    logic         vld_q;
    logic         halted_q;
    logic         fault_q;
    logic         npc_bad;
    logic         retire;
    logic         advance;

    // Addresses beyond the ROM fault instead of wrapping back to word 0.
    assign npc_bad = (bus.npc_in[1:0] != 2'b00) || (bus.npc_in[31:AW+2] != '0);
    assign retire  = (state == RUN) && !bus.stall_in;
    assign advance = retire && !bus.halt_in && !npc_bad;

    // The ROM samples this at the coming edge, so it must already point at the next PC.
    assign bus.rom_addr = !reset_n ? RESET_PC[AW+1:2] :
                          advance  ? bus.npc_in[AW+1:2] :
                                     pc_q[AW+1:2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= FILL;
            pc_q         <= RESET_PC;
            vld_q        <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            case (state)
                FILL: begin
                    state <= RUN;
                    vld_q <= 1'b1;
                end
                RUN: begin
                    if (retire) begin
                        if (bus.halt_in) begin
                            state    <= HALTED;
                            vld_q    <= 1'b0;
                            halted_q <= 1'b1;
                        end else if (npc_bad) begin
                            state        <= HALTED;
                            vld_q        <= 1'b0;
                            halted_q     <= 1'b1;
                            fault_q      <= 1'b1;
                            fault_addr_q <= bus.npc_in;
                        end else begin
                            pc_q <= bus.npc_in;
                        end
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

    sat_counter u_retired (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (retire),
        .count   (bus.retired)
    );

    assign bus.instr_out   = vld_q ? bus.rom_q : NOP;
    assign bus.pc_out      = pc_q;
    assign bus.instr_valid = vld_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.fault_addr  = fault_addr_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: synchronous ROM model plus a queue of expected PCs per fetch.
module tb_instruction_fetch;
    localparam int          AW    = 6;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    instruction_fetch_if #(.AW(AW)) bus ();

    instruction_fetch #(.AW(AW), .RESET_PC(32'h0), .NOP(NOP_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] rom [0:63];
    always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc_q [$];
    logic [31:0] exp_retired;
    logic [31:0] pc;

    task automatic do_reset();
        reset_n = 1'b0; bus.stall_in = 1'b0; bus.halt_in = 1'b0; bus.npc_in = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        exp_retired = 32'h0;
        exp_pc_q.delete();
    endtask

    // Drives one non-stalled sequential step and records the PC that should appear next.
    task automatic step_to(input logic [31:0] npc);
        bus.npc_in = npc;
        exp_pc_q.push_back(npc);
        exp_retired = exp_retired + 32'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; bus.stall_in = 1'b0; bus.halt_in = 1'b0; bus.npc_in = 32'h0;
        @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", bus.instr_valid); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b, expected 0", bus.halted); end
        n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b, expected 0", bus.fault); end
        n_checks++; if (bus.fault_addr !== 32'h0) begin n_fail++; $display("FAIL rst_fault_addr: got %h, expected 0", bus.fault_addr); end
        n_checks++; if (bus.retired !== 32'h0) begin n_fail++; $display("FAIL rst_retired: got %h, expected 0", bus.retired); end
        n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h, expected 0", bus.pc_out); end
        n_checks++; if (bus.instr_out !== NOP_W) begin n_fail++; $display("FAIL rst_instr: got %h, expected %h", bus.instr_out, NOP_W); end
        n_checks++; if (bus.rom_addr !== 6'd0) begin n_fail++; $display("FAIL rst_rom_addr: got %h, expected 0", bus.rom_addr); end
        reset_n = 1'b1;
        #1;
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL fill_valid: got %b, expected 0", bus.instr_valid); end
        n_checks++; if (bus.rom_addr !== 6'd0) begin n_fail++; $display("FAIL fill_rom_addr: got %h, expected 0", bus.rom_addr); end
        @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b, expected 1", bus.instr_valid); end
        n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL first_pc: got %h, expected 0", bus.pc_out); end
        n_checks++; if (bus.instr_out !== rom[0]) begin n_fail++; $display("FAIL first_instr: got %h, expected %h", bus.instr_out, rom[0]); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            bus.npc_in = 32'(i * 4);
            #1;
            n_checks++; if (bus.rom_addr !== 6'(i)) begin n_fail++; $display("FAIL seq_rom_addr: got %0d, expected %0d", bus.rom_addr, i); end
            step_to(32'(i * 4));
            pc = exp_pc_q.pop_front();
            n_checks++; if (bus.pc_out !== pc) begin n_fail++; $display("FAIL seq_pc: got %h, expected %h", bus.pc_out, pc); end
            n_checks++; if (bus.instr_out !== rom[pc[AW+1:2]]) begin n_fail++; $display("FAIL seq_instr: got %h, expected %h", bus.instr_out, rom[pc[AW+1:2]]); end
            n_checks++; if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL seq_retired: got %0d, expected %0d", bus.retired, exp_retired); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step_to(32'd4);
        step_to(32'd8);
        exp_pc_q.delete();
        bus.stall_in = 1'b1;
        bus.npc_in   = 32'h20;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.rom_addr !== 6'd2) begin n_fail++; $display("FAIL stall_rom_addr: got %0d, expected 2", bus.rom_addr); end
            @(negedge clk);
            n_checks++; if (bus.pc_out !== 32'd8) begin n_fail++; $display("FAIL stall_pc: got %h, expected 8", bus.pc_out); end
            n_checks++; if (bus.instr_out !== rom[2]) begin n_fail++; $display("FAIL stall_instr: got %h, expected %h", bus.instr_out, rom[2]); end
            n_checks++; if (bus.retired !== 32'd2) begin n_fail++; $display("FAIL stall_retired: got %0d, expected 2", bus.retired); end
        end
        bus.stall_in = 1'b0;
        step_to(32'd12);
        pc = exp_pc_q.pop_front();
        n_checks++; if (bus.pc_out !== pc) begin n_fail++; $display("FAIL unstall_pc: got %h, expected %h", bus.pc_out, pc); end
        n_checks++; if (bus.instr_out !== rom[3]) begin n_fail++; $display("FAIL unstall_instr: got %h, expected %h", bus.instr_out, rom[3]); end
        n_checks++; if (bus.retired !== 32'd3) begin n_fail++; $display("FAIL unstall_retired: got %0d, expected 3", bus.retired); end
    endtask

    task automatic test_halt_stall();
        do_reset();
        step_to(32'd4);
        bus.halt_in  = 1'b1;
        bus.stall_in = 1'b1;
        bus.npc_in   = 32'd8;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_stalled: got %b, expected 0", bus.halted); end
            n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL halt_stalled_valid: got %b, expected 1", bus.instr_valid); end
        end
        bus.stall_in = 1'b0;
        #1;
        n_checks++; if (bus.rom_addr !== 6'd1) begin n_fail++; $display("FAIL halt_rom_addr: got %0d, expected 1", bus.rom_addr); end
        @(negedge clk);
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %b, expected 1", bus.halted); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b, expected 0", bus.instr_valid); end
        n_checks++; if (bus.instr_out !== NOP_W) begin n_fail++; $display("FAIL halt_instr: got %h, expected %h", bus.instr_out, NOP_W); end
        n_checks++; if (bus.retired !== 32'd2) begin n_fail++; $display("FAIL halt_retired: got %0d, expected 2", bus.retired); end
        n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL halt_fault: got %b, expected 0", bus.fault); end
        bus.halt_in = 1'b0;
        bus.npc_in  = 32'd8;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b, expected 1", bus.halted); end
        n_checks++; if (bus.pc_out !== 32'd4) begin n_fail++; $display("FAIL halt_pc_held: got %h, expected 4", bus.pc_out); end
        n_checks++; if (bus.rom_addr !== 6'd1) begin n_fail++; $display("FAIL halt_rom_held: got %0d, expected 1", bus.rom_addr); end
        n_checks++; if (bus.retired !== 32'd2) begin n_fail++; $display("FAIL halt_retired_held: got %0d, expected 2", bus.retired); end
    endtask

    task automatic test_fault_misaligned();
        do_reset();
        bus.npc_in = 32'h0000_0006;
        @(negedge clk);
        n_checks++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b, expected 1", bus.fault); end
        n_checks++; if (bus.fault_addr !== 32'h6) begin n_fail++; $display("FAIL mis_fault_addr: got %h, expected 6", bus.fault_addr); end
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL mis_halted: got %b, expected 1", bus.halted); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b, expected 0", bus.instr_valid); end
        n_checks++; if (bus.retired !== 32'd1) begin n_fail++; $display("FAIL mis_retired: got %0d, expected 1", bus.retired); end
        n_checks++; if (bus.pc_out !== 32'd0) begin n_fail++; $display("FAIL mis_pc: got %h, expected 0", bus.pc_out); end
    endtask

    task automatic test_fault_range();
        do_reset();
        step_to(32'd252);
        pc = exp_pc_q.pop_front();
        n_checks++; if (bus.pc_out !== pc) begin n_fail++; $display("FAIL last_pc: got %h, expected %h", bus.pc_out, pc); end
        n_checks++; if (bus.instr_out !== rom[63]) begin n_fail++; $display("FAIL last_instr: got %h, expected %h", bus.instr_out, rom[63]); end
        bus.npc_in = 32'h0000_0100;
        @(negedge clk);
        n_checks++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL range_fault: got %b, expected 1", bus.fault); end
        n_checks++; if (bus.fault_addr !== 32'h100) begin n_fail++; $display("FAIL range_fault_addr: got %h, expected 100", bus.fault_addr); end
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL range_halted: got %b, expected 1", bus.halted); end
        n_checks++; if (bus.rom_addr !== 6'd63) begin n_fail++; $display("FAIL range_rom_addr: got %0d, expected 63", bus.rom_addr); end
    endtask

    task automatic test_saturate();
        reset_n = 1'b0; bus.stall_in = 1'b0; bus.halt_in = 1'b0; bus.npc_in = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        force dut.u_retired.count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.u_retired.count_q;
        exp_pc_q.delete();
        exp_retired = 32'hFFFF_FFFE;
        n_checks++; if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL sat_preload: got %h, expected %h", bus.retired, exp_retired); end
        for (int i = 1; i <= 3; i++) begin
            bus.npc_in = 32'(i * 4);
            exp_pc_q.push_back(32'(i * 4));
            if (exp_retired != 32'hFFFF_FFFF) exp_retired = exp_retired + 32'd1;
            @(negedge clk);
            pc = exp_pc_q.pop_front();
            n_checks++; if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL sat_retired: got %h, expected %h", bus.retired, exp_retired); end
            n_checks++; if (bus.pc_out !== pc) begin n_fail++; $display("FAIL sat_pc: got %h, expected %h", bus.pc_out, pc); end
        end
    endtask

    task automatic test_reset_from_fault();
        do_reset();
        bus.npc_in = 32'h0000_0006;
        @(negedge clk);
        n_checks++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL rf_pre_fault: got %b, expected 1", bus.fault); end
        reset_n = 1'b0; bus.halt_in = 1'b1; bus.stall_in = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL rf_fault: got %b, expected 0", bus.fault); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rf_halted: got %b, expected 0", bus.halted); end
        n_checks++; if (bus.fault_addr !== 32'h0) begin n_fail++; $display("FAIL rf_fault_addr: got %h, expected 0", bus.fault_addr); end
        n_checks++; if (bus.retired !== 32'h0) begin n_fail++; $display("FAIL rf_retired: got %h, expected 0", bus.retired); end
        n_checks++; if (bus.instr_out !== NOP_W) begin n_fail++; $display("FAIL rf_instr: got %h, expected %h", bus.instr_out, NOP_W); end
        reset_n = 1'b1; bus.halt_in = 1'b0; bus.stall_in = 1'b0; bus.npc_in = 32'd4;
        #1;
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rf_fill_valid: got %b, expected 0", bus.instr_valid); end
        @(negedge clk);
        n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rf_run_valid: got %b, expected 1", bus.instr_valid); end
        n_checks++; if (bus.instr_out !== rom[0]) begin n_fail++; $display("FAIL rf_run_instr: got %h, expected %h", bus.instr_out, rom[0]); end
        n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL rf_run_pc: got %h, expected 0", bus.pc_out); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hCAFE_0000 | (32'(i) << 4) | 32'h3;
        reset_n = 1'b0;
        bus.stall_in = 1'b0;
        bus.halt_in  = 1'b0;
        bus.npc_in   = 32'h0;
        exp_retired  = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_halt_stall();
        test_fault_misaligned();
        test_fault_range();
        test_saturate();
        test_reset_from_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly upstream of the single-cycle `datapath`, between it and the instruction ROM. It owns the program counter, drives the synchronous ROM address and masks the ROM's one-cycle read latency after reset. It freezes fetch on halt, stall or a bad next-PC, and presents a validated instruction plus its PC to the datapath. It replaces the level-sensitive PC latch in the processor top level with a clean registered fetch.

## Interface
- `AW`, 6: ROM word-address width (64 words).
- `RESET_PC`, 0: byte address fetched first after reset; word-aligned.
- `NOP`, 32'h0000_0013: instruction word driven when `instr_valid`=0.
- `clk` in 1: single processor clock; all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `npc_in` in 32: next-PC byte address from the datapath for the current instruction.
- `halt_in` in 1: datapath decoded halt (opcode 7'b1111111) in the current instruction.
- `stall_in` in 1: hold the current instruction for another cycle (data-memory busy).
- `rom_addr` out AW: combinational word address sampled by the ROM at the next edge.
- `rom_q` in 32: ROM read data, valid the cycle after its address is sampled.
- `instr_out` out 32: current instruction; `NOP` when not valid.
- `pc_out` out 32: byte address of `instr_out`.
- `instr_valid` out 1: `instr_out` is a real instruction to execute.
- `halted` out 1: sticky, fetch stopped by halt or fault.
- `fault` out 1: sticky, stop caused by a bad `npc_in`.
- `fault_addr` out 32: offending `npc_in`; 0 unless `fault`=1.
- `retired` out 32: saturating count of retired instructions.

## Operation
- States: FILL, RUN, HALTED.
- Reset (`reset_n`=0 at an edge) forces FILL. Reset values: `pc_q`=`RESET_PC`, `instr_valid`=0, `halted`=0, `fault`=0, `fault_addr`=0, `retired`=0. `rom_addr` is `RESET_PC[AW+1:2]` while `reset_n`=0.
- FILL: one cycle. `instr_valid`=0 and `rom_addr`=`pc_q[AW+1:2]`. Next state is RUN.
- RUN: `instr_valid`=1, `instr_out`=`rom_q`, `pc_out`=`pc_q`.
  - Retire condition: `stall_in`=0. Retiring increments `retired`, which saturates at 32'hFFFF_FFFF.
  - With `stall_in`=1: `rom_addr`=`pc_q[AW+1:2]`, `pc_q` is held, no retire. Stall beats halt and fault checks.
  - Retire with `halt_in`=1 goes to HALTED. `pc_q` is held. The halt instruction counts as retired.
  - Retire with `halt_in`=0 and a bad `npc_in` goes to HALTED, sets `fault`=1 and `fault_addr`=`npc_in`, and holds `pc_q`. The instruction counts as retired. `halt_in` beats fault.
  - A bad `npc_in` is either `npc_in[1:0]`≠0 or any bit of `npc_in[31:AW+2]`≠0.
  - Otherwise: `rom_addr`=`npc_in[AW+1:2]` and `pc_q`←`npc_in`.
- HALTED: `instr_valid`=0, `instr_out`=`NOP`, and `rom_addr`=`pc_q[AW+1:2]` is held. Only reset leaves this state. All inputs are ignored.
- No wrap-around: the last word (byte 4·(2^AW−1)) with `npc_in`=4·2^AW faults rather than wrapping to 0.

## Timing
- Fetch latency is one cycle. The address placed on `rom_addr` in cycle n appears on `instr_out` in cycle n+1.
- Throughput is one instruction per cycle when `stall_in`=0.
- First valid instruction: the second cycle after `reset_n` is sampled high (one FILL bubble).
- `halted`/`fault` assert in the cycle after the retiring halt/faulting instruction, together with `instr_valid`=0.
- Reset asserted mid-RUN or in HALTED takes effect at the next edge regardless of stall or halt.

## Structure
- Package `fetch_pkg`: the state enum `fetch_state_t` (FILL, RUN, HALTED) and the `NOP` default constant.
- One natural sub-module, `sat_counter`, a 32-bit saturating counter with an increment enable, used for `retired`.
- The rest is the next-PC mux, the bad-PC check and the FSM in `instruction_fetch`.

## Test plan
- Reset, then release. Expected: `instr_valid`=0 for one cycle, then `pc_out`=0 and `instr_out`=ROM[0]. `rom_addr` follows sequential `npc_in` (4, 8, 12) as 1, 2, 3.
- Drive `stall_in`=1 for 3 cycles at pc 8. Expected: `rom_addr`=2 and `instr_out`/`pc_out` stable for those cycles, `retired` unchanged. After release, `pc_out`=`npc_in`.
- `halt_in`=1 with `stall_in`=1 for 2 cycles, then `stall_in`=0. Expected: halt takes effect only after the stall drops, `halted`=1 next cycle, `retired` includes the halt instruction, `instr_out`=32'h0000_0013.
- `npc_in`=32'h0000_0006 (misaligned). Expected: `fault`=1, `fault_addr`=6, `halted`=1. Then `npc_in`=32'h0000_0100 with AW=6 after reset: same response with `fault_addr`=32'h100.
- Preload `retired`=32'hFFFF_FFFE via force, then run 3 instructions. Expected: `retired` saturates at 32'hFFFF_FFFF.
- Assert `reset_n`=0 for one cycle while in HALTED with `fault`=1. Expected: all outputs return to their reset values and FILL repeats.
